message_display_ctrl: RTL
=========================

// Module: message_display_ctrl
// PURPOSE
//  Sequences an 80x20 message bitmap (e.g. "try again") on the VGA path.
//  Feeds the bitmap's draw/InsideRectangle/offsetX/offsetY inputs from the VGA pixel scan.
//  On a show request the message blinks for a fixed number of frames, then holds steady until dismissed.
//  Sits between the game controller (showReq/dismiss) and the message bitmap ahead of the object mux.
// PARAMETERS
//  OBJECT_WIDTH_X   80   message width in pixels
//  OBJECT_HEIGHT_Y  20   message height in pixels
//  TOP_LEFT_X       280  screen X of message top-left corner
//  TOP_LEFT_Y       230  screen Y of message top-left corner
//  BLINK_FRAMES     30   frames per blink half-period (>=1)
//  SHOW_FRAMES      180  total frames spent blinking before HOLD (>=1)
//  HOLD_FRAMES      300  auto-dismiss timeout in HOLD (used only with MSG_AUTO_DISMISS_EN)
// PORTS
//  clk              in   1   pixel clock
//  resetN           in   1   asynchronous active-low reset
//  startOfFrame     in   1   one-cycle pulse per VGA frame
//  pixelX           in   11  current scan X
//  pixelY           in   11  current scan Y
//  showReq          in   1   one-cycle pulse: start message sequence
//  dismiss          in   1   one-cycle pulse: remove message
//  draw             out  1   to bitmap: message visible this pixel
//  InsideRectangle  out  1   to bitmap: pixel inside message rectangle
//  offsetX          out  11  to bitmap: pixelX - TOP_LEFT_X when inside, else 0
//  offsetY          out  11  to bitmap: pixelY - TOP_LEFT_Y when inside, else 0
//  busy             out  1   1 in any state other than IDLE
//  done             out  1   one-cycle pulse when returning to IDLE from an active state
// BEHAVIOUR
//  - Reset: state=IDLE, all counters 0, every output 0.
//  - States: IDLE, BLINK_ON, BLINK_OFF, HOLD.
//  - IDLE: showReq -> BLINK_ON. frameCnt and blinkCnt are cleared on entry. dismiss is ignored.
//  - Frame counting happens only on cycles with startOfFrame=1 in BLINK_ON or BLINK_OFF:
//      - frameCnt increments.
//      - blinkCnt increments. When it reaches BLINK_FRAMES-1 it clears and toggles BLINK_ON<->BLINK_OFF.
//      - When frameCnt==SHOW_FRAMES-1 -> HOLD (precedence over toggle).
//  - HOLD: stays until dismiss.
//  - dismiss in BLINK_ON/BLINK_OFF/HOLD -> IDLE next cycle, with done=1 for that one cycle.
//  - showReq while busy: ignored; no restart.
//  - showReq and dismiss in the same cycle:
//      - in IDLE, showReq wins;
//      - when busy, dismiss wins.
//  - Counters are 16-bit unsigned. Parameters must fit.
//  - Geometry:
//      - inside = (TOP_LEFT_X <= pixelX < TOP_LEFT_X+OBJECT_WIDTH_X) && (TOP_LEFT_Y <= pixelY < TOP_LEFT_Y+OBJECT_HEIGHT_Y).
//      - Use unsigned 11-bit compares. There is no wrap: the rectangle must lie fully on screen.
//  - Output timing: InsideRectangle, offsetX and offsetY are registered, 1-cycle latency from pixelX/pixelY.
//  - draw:
//      - registered, = 1 in BLINK_ON or HOLD (state as of the previous cycle), else 0;
//      - independent of inside, because the bitmap ANDs draw with InsideRectangle.
//  - busy: registered, reflects the current state.
//  - Reset mid-sequence: immediate return to IDLE, outputs 0, no done pulse.
// CONFIGURATION
//  - `MSG_AUTO_DISMISS_EN defined:
//      - HOLD counts startOfFrame pulses.
//      - After HOLD_FRAMES pulses it returns to IDLE with a done pulse, exactly as on dismiss.
//      - An external dismiss still exits earlier.
//  - Not defined: HOLD persists until dismiss; HOLD_FRAMES is unused.
// TESTING (BLINK_FRAMES=2, SHOW_FRAMES=6, HOLD_FRAMES=3 unless noted)
//  1. Reset then idle scan -> draw=0, busy=0, InsideRectangle=0 for all pixels, done never pulses.
//  2. showReq, then 6 SOF pulses -> states ON,ON,OFF,OFF,ON,ON; HOLD after 6th SOF; draw=1 in HOLD.
//  3. Scan in HOLD -> (280,230): Inside=1, offset=(0,0). (359,249): offset=(79,19). (360,230) and (279,249): Inside=0, offset=(0,0). All 1 cycle late.
//  4. dismiss in BLINK_OFF -> IDLE next cycle, done=1 for 1 cycle, busy=0. showReq+dismiss in IDLE -> BLINK_ON.
//  5. showReq while busy (HOLD) -> state unchanged, counters unchanged. resetN low mid-BLINK -> all outputs 0, no done.
//  6. With MSG_AUTO_DISMISS_EN: 3 SOF in HOLD -> IDLE with done pulse. Without it: 10 SOF in HOLD -> still HOLD.

Source files
------------

// File: rtl/message_display_ctrl_if.sv
// Signal bundle between the game controller / VGA scan and the
// message display sequencer, and from it to the message bitmap.
interface message_display_ctrl_if;
  logic        startOfFrame;
  logic [10:0] pixelX;
  logic [10:0] pixelY;
  logic        showReq;
  logic        dismiss;
  logic        draw;
  logic        InsideRectangle;
  logic [10:0] offsetX;
  logic [10:0] offsetY;
  logic        busy;
  logic        done;

  modport master (
    output startOfFrame,
    output pixelX,
    output pixelY,
    output showReq,
    output dismiss,
    input  draw,
    input  InsideRectangle,
    input  offsetX,
    input  offsetY,
    input  busy,
    input  done
  );

  modport slave (
    input  startOfFrame,
    input  pixelX,
    input  pixelY,
    input  showReq,
    input  dismiss,
    output draw,
    output InsideRectangle,
    output offsetX,
    output offsetY,
    output busy,
    output done
  );
endinterface

// File: rtl/message_display_ctrl.sv
// Message display sequencer: blinks a bitmap message, then holds it.
// Optional MSG_AUTO_DISMISS_EN: HOLD times out after HOLD_FRAMES frames.
module message_display_ctrl #(
  parameter int OBJECT_WIDTH_X  = 80,
  parameter int OBJECT_HEIGHT_Y = 20,
  parameter int TOP_LEFT_X      = 280,
  parameter int TOP_LEFT_Y      = 230,
  parameter int BLINK_FRAMES    = 30,
  parameter int SHOW_FRAMES     = 180,
  parameter int HOLD_FRAMES     = 300
) (
  input logic                   clk,
  input logic                   resetN,
  message_display_ctrl_if.slave bus
);

  localparam logic [10:0] X_LO = 11'(TOP_LEFT_X);
  localparam logic [10:0] X_HI = 11'(TOP_LEFT_X + OBJECT_WIDTH_X);
  localparam logic [10:0] Y_LO = 11'(TOP_LEFT_Y);
  localparam logic [10:0] Y_HI = 11'(TOP_LEFT_Y + OBJECT_HEIGHT_Y);

  localparam logic [15:0] BLINK_LAST = 16'(BLINK_FRAMES - 1);
  localparam logic [15:0] SHOW_LAST  = 16'(SHOW_FRAMES - 1);
`ifdef MSG_AUTO_DISMISS_EN
  localparam logic [15:0] HOLD_LAST  = 16'(HOLD_FRAMES - 1);
`endif

  // Elaboration-time parameter sanity: counters are 16 bits,
  // the rectangle must lie inside the 11-bit coordinate space.
  if (BLINK_FRAMES < 1 || BLINK_FRAMES > 65535) begin : g_bad_blink
    $error("BLINK_FRAMES out of range");
  end
  if (SHOW_FRAMES < 1 || SHOW_FRAMES > 65535) begin : g_bad_show
    $error("SHOW_FRAMES out of range");
  end
  if (HOLD_FRAMES < 1 || HOLD_FRAMES > 65535) begin : g_bad_hold
    $error("HOLD_FRAMES out of range");
  end
  if (TOP_LEFT_X + OBJECT_WIDTH_X > 2047 ||
      TOP_LEFT_Y + OBJECT_HEIGHT_Y > 2047) begin : g_bad_geom
    $error("message rectangle off screen");
  end

  typedef enum logic [1:0] {
    IDLE,
    BLINK_ON,
    BLINK_OFF,
    HOLD
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] frame_q, frame_d;
  logic [15:0] blink_q, blink_d;

  logic        draw_q;
  logic        busy_q;
  logic        done_q;
  logic        inside_q, inside_d;
  logic [10:0] offx_q, offx_d;
  logic [10:0] offy_q, offy_d;

  logic        in_rect;
  logic        active;

  assign active = (state_q != IDLE);

  // Sequencer next state and frame/blink counters.
  // frameCnt doubles as the HOLD timer, so it restarts on HOLD entry.
  always_comb begin
    state_d = state_q;
    frame_d = frame_q;
    blink_d = blink_q;
    unique case (state_q)
      IDLE: begin
        if (bus.showReq) begin
          state_d = BLINK_ON;
          frame_d = '0;
          blink_d = '0;
        end
      end
      BLINK_ON, BLINK_OFF: begin
        if (bus.dismiss) begin
          state_d = IDLE;
        end else if (bus.startOfFrame) begin
          frame_d = frame_q + 16'd1;
          if (frame_q == SHOW_LAST) begin
            state_d = HOLD;
            frame_d = '0;
            blink_d = '0;
          end else if (blink_q == BLINK_LAST) begin
            blink_d = '0;
            state_d = (state_q == BLINK_ON) ? BLINK_OFF : BLINK_ON;
          end else begin
            blink_d = blink_q + 16'd1;
          end
        end
      end
      HOLD: begin
        if (bus.dismiss) begin
          state_d = IDLE;
        end
`ifdef MSG_AUTO_DISMISS_EN
        else if (bus.startOfFrame) begin
          if (frame_q == HOLD_LAST) begin
            state_d = IDLE;
          end else begin
            frame_d = frame_q + 16'd1;
          end
        end
`endif
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Rectangle hit test; the rectangle is only reported while a
  // message sequence is active, so an idle scan never lights it.
  always_comb begin
    in_rect  = (bus.pixelX >= X_LO) && (bus.pixelX < X_HI) &&
               (bus.pixelY >= Y_LO) && (bus.pixelY < Y_HI);
    inside_d = in_rect && active;
    offx_d   = '0;
    offy_d   = '0;
    if (inside_d) begin
      offx_d = bus.pixelX - X_LO;
      offy_d = bus.pixelY - Y_LO;
    end
  end

  // State and counter registers.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q <= IDLE;
      frame_q <= '0;
      blink_q <= '0;
    end else begin
      state_q <= state_d;
      frame_q <= frame_d;
      blink_q <= blink_d;
    end
  end

  // Registered outputs: draw follows the previous cycle's state,
  // busy the new state, done marks the cycle IDLE is re-entered.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      draw_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      inside_q <= 1'b0;
      offx_q   <= '0;
      offy_q   <= '0;
    end else begin
      draw_q   <= (state_q == BLINK_ON) || (state_q == HOLD);
      busy_q   <= (state_d != IDLE);
      done_q   <= active && (state_d == IDLE);
      inside_q <= inside_d;
      offx_q   <= offx_d;
      offy_q   <= offy_d;
    end
  end

  assign bus.draw            = draw_q;
  assign bus.busy            = busy_q;
  assign bus.done            = done_q;
  assign bus.InsideRectangle = inside_q;
  assign bus.offsetX         = offx_q;
  assign bus.offsetY         = offy_q;

endmodule
